// File: rtl/vector_stream_alu.sv
// Streaming vector ALU: LANES elements per clock over the active length.
// Define VECTOR_ALU_SATURATE_EN for saturating add/sub/mul.
module vector_stream_alu #(
  parameter int BITS       = 8,
  parameter int N          = 64,
  parameter int LANES      = 8,
  parameter int MULT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op_sel,
  input  logic                     scalar_sel,
  input  logic [BITS-1:0]          scalar,
  input  logic [N-1:0][BITS-1:0]   A,
  input  logic [BITS-1:0]          A_len,
  input  logic [N-1:0][BITS-1:0]   B,
  input  logic [BITS-1:0]          B_len,
  output logic                     busy,
  output logic                     done,
  output logic [N-1:0][BITS-1:0]   S,
  output logic [BITS-1:0]          S_len
);

  localparam int CH = N / LANES;
  localparam int KW = (CH > 1) ? $clog2(CH) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int NW = $clog2(N + 1);
  localparam int LW = ((BITS > NW) ? BITS : NW) + 1;
  localparam int PW = 2 * BITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, next;
  logic [N-1:0][BITS-1:0]   a_r, b_r;
  logic [2:0]               op_r;
  logic [LW-1:0]            a_len_r, b_len_r, len_r;
  logic [KW-1:0]            k;
  logic [LW-1:0]            a_eff, b_eff, len_new, base;
  logic                     last;
  logic [LANES-1:0][BITS-1:0] res;

`ifdef VECTOR_ALU_SATURATE_EN
  localparam logic signed [PW-1:0] SMAX = PW'(2 ** (BITS - 1) - 1);
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  function automatic logic [BITS-1:0] fit(input logic signed [PW-1:0] v);
    if (v > SMAX)      fit = SMAX[BITS-1:0];
    else if (v < SMIN) fit = SMIN[BITS-1:0];
    else               fit = v[BITS-1:0];
  endfunction
`else
  function automatic logic [BITS-1:0] fit(input logic signed [PW-1:0] v);
    fit = v[BITS-1:0];
  endfunction
`endif

  function automatic logic [BITS-1:0] alu(
    input logic [2:0]      op,
    input logic [BITS-1:0] a,
    input logic [BITS-1:0] b
  );
    logic signed [PW-1:0] sa, sb, prod;
    sa   = PW'($signed(a));
    sb   = PW'($signed(b));
    prod = (sa * sb) >>> MULT_SHIFT;
    alu  = '0;
    unique case (op)
      3'b000: alu = fit(sa + sb);
      3'b001: alu = fit(sa - sb);
      3'b010: alu = fit(prod);
      3'b011: alu = (sa > sb) ? BITS'(1) : ((sa == sb) ? '0 : '1);
      3'b100: alu = a & b;
      3'b101: alu = a | b;
      3'b110: alu = a ^ b;
      3'b111: alu = ~a;
      default: alu = '0;
    endcase
  endfunction

  always_comb begin
    a_eff   = (LW'(A_len) > LW'(N)) ? LW'(N) : LW'(A_len);
    b_eff   = (LW'(B_len) > LW'(N)) ? LW'(N) : LW'(B_len);
    len_new = scalar_sel ? a_eff : ((a_eff > b_eff) ? a_eff : b_eff);
    base    = LW'(k) * LW'(LANES);
    last    = (base + LW'(LANES)) >= len_r;
  end

  // One chunk of lanes; indices past an operand's length read as zero
  always_comb begin
    logic [LW-1:0]   idx;
    logic [BITS-1:0] av, bv;
    idx = '0;
    av  = '0;
    bv  = '0;
    res = '0;
    for (int j = 0; j < LANES; j++) begin
      idx    = base + LW'(j);
      av     = (idx < a_len_r) ? a_r[idx[IW-1:0]] : '0;
      bv     = (idx < b_len_r) ? b_r[idx[IW-1:0]] : '0;
      res[j] = (idx < len_r) ? alu(op_r, av, bv) : '0;
    end
  end

  always_comb begin
    next = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: if (start) next = (len_new == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last) next = DONE;
      end
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      S     <= '0;
      len_r <= '0;
    end else begin
      state <= next;
      unique case (state)
        IDLE: if (start) begin
          a_r     <= A;
          op_r    <= op_sel;
          a_len_r <= a_eff;
          // broadcast scalar covers every index
          b_len_r <= scalar_sel ? LW'(N) : b_eff;
          for (int i = 0; i < N; i++)
            b_r[i] <= scalar_sel ? scalar : B[i];
          len_r   <= len_new;
          k       <= '0;
          S       <= '0;
        end
        RUN: begin
          for (int c = 0; c < CH; c++)
            if (k == KW'(c))
              for (int j = 0; j < LANES; j++)
                S[c*LANES+j] <= res[j];
          k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign S_len = len_r[BITS-1:0];

endmodule

// File: tb/tb_vector_stream_alu.sv
// Bench for vector_stream_alu: timeline model, per-cycle compare,
// directed literal cases and randomized operations.
module tb_vector_stream_alu;
  localparam int BITS  = 8;
  localparam int N     = 64;
  localparam int LANES = 8;
  localparam int MSH   = 0;
  localparam int MAXV  = 2 ** (BITS - 1) - 1;
  localparam int MINV  = -(2 ** (BITS - 1));

  logic                   clk = 1'b0;
  logic                   rst, start, scalar_sel;
  logic [2:0]             op_sel;
  logic [BITS-1:0]        scalar, A_len, B_len, S_len;
  logic [N-1:0][BITS-1:0] A, B, S, exp_s;
  logic                   busy, done;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  int m_t = 0;
  int m_c = 0;
  int m_len = 0;
  logic [BITS-1:0] m_fin [N];

  vector_stream_alu #(
    .BITS(BITS), .N(N), .LANES(LANES), .MULT_SHIFT(MSH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
    .scalar_sel(scalar_sel), .scalar(scalar),
    .A(A), .A_len(A_len), .B(B), .B_len(B_len),
    .busy(busy), .done(done), .S(S), .S_len(S_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want,
               $time);
    end
  endtask

  function automatic int sx(input logic [BITS-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [BITS-1:0] fitv(input int v);
`ifdef VECTOR_ALU_SATURATE_EN
    if (v > MAXV) return BITS'(MAXV);
    if (v < MINV) return BITS'(MINV);
`endif
    return BITS'(v);
  endfunction

  function automatic logic [BITS-1:0] ref_op(input logic [2:0] op,
      input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    case (op)
      3'd0: return fitv(sx(a) + sx(b));
      3'd1: return fitv(sx(a) - sx(b));
      3'd2: return fitv((sx(a) * sx(b)) >>> MSH);
      3'd3: return (sx(a) > sx(b)) ? BITS'(1) :
                   ((sx(a) == sx(b)) ? BITS'(0) : '1);
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Model: m_t counts edges since acceptance (0 = idle)
  always @(posedge clk) begin
    int ea, eb;
    logic [BITS-1:0] av, bv;
    if (rst) begin
      m_t = 0;
      m_len = 0;
      for (int i = 0; i < N; i++) m_fin[i] = '0;
    end else if (m_t == 0) begin
      if (start) begin
        ea = (int'(A_len) > N) ? N : int'(A_len);
        eb = (int'(B_len) > N) ? N : int'(B_len);
        m_len = scalar_sel ? ea : ((ea > eb) ? ea : eb);
        for (int i = 0; i < N; i++) begin
          av = (i < ea) ? A[i] : '0;
          bv = scalar_sel ? scalar : ((i < eb) ? B[i] : '0);
          m_fin[i] = (i < m_len) ? ref_op(op_sel, av, bv) : '0;
        end
        m_c = (m_len + LANES - 1) / LANES;
        m_t = 1;
      end
    end else if (m_t == m_c + 1) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("busy", 32'(busy), 32'(m_t >= 1 && m_t <= m_c));
      chk("done", 32'(done), 32'(m_t >= 1 && m_t == m_c + 1));
      chk("s_len", 32'(S_len), 32'(m_len));
      for (int i = 0; i < N; i++)
        exp_s[i] = (m_t == 0 || i < (m_t - 1) * LANES) ? m_fin[i] : '0;
      tests++;
      if (S !== exp_s) begin
        fails++;
        for (int i = N - 1; i >= 0; i--)
          if (S[i] !== exp_s[i])
            $display("FAIL s_vec idx=%0d got=%0h expected=%0h at %0t",
                     i, S[i], exp_s[i], $time);
      end
    end
  end

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      A[i] = BITS'($urandom);
      B[i] = BITS'($urandom);
    end
    op_sel = 3'($urandom);
    scalar_sel = 1'($urandom);
    scalar = BITS'($urandom);
    A_len = BITS'($urandom);
    B_len = BITS'($urandom);
  endtask

  // Issue the prepared op, then scramble inputs to prove they were latched
  task automatic go(input bit hold, output int lat, output int nbusy);
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    nbusy = 0;
    if (!hold) start = 1'b0;
    scramble();
    forever begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) break;
      if (lat > N / LANES + 4) begin
        chk("done_timeout", 32'(lat), 32'(N / LANES + 1));
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [2:0] op, input bit ss,
                       input int sc, input int al, input int bl);
    op_sel = op;
    scalar_sel = ss;
    scalar = BITS'(sc);
    A_len = BITS'(al);
    B_len = BITS'(bl);
  endtask

  int lat, nb;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    setup(3'd0, 1'b0, 0, 0, 0);
    A = '0;
    B = '0;
    @(posedge clk);
    #1;
    checking = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_slen", 32'(S_len), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < N; i++) begin A[i] = BITS'(i); B[i] = 8'd2; end
    setup(3'd0, 1'b0, 0, 20, 20);
    go(1'b0, lat, nb);
    chk("add_lat", 32'(lat), 32'd4);
    chk("add_busy", 32'(nb), 32'd3);
    chk("add_slen", 32'(S_len), 32'd20);
    chk("add_s0", 32'(S[0]), 32'd2);
    chk("add_s19", 32'(S[19]), 32'd21);
    chk("add_s20", 32'(S[20]), 32'd0);

    for (int i = 0; i < N; i++) begin A[i] = 8'd10; B[i] = 8'h55; end
    setup(3'd1, 1'b1, 3, 5, 40);
    go(1'b0, lat, nb);
    chk("sub_lat", 32'(lat), 32'd2);
    chk("sub_slen", 32'(S_len), 32'd5);
    chk("sub_s4", 32'(S[4]), 32'd7);
    chk("sub_s5", 32'(S[5]), 32'd0);

    for (int i = 0; i < N; i++) begin A[i] = 8'hFF; B[i] = 8'h0F; end
    setup(3'd6, 1'b0, 0, 3, 10);
    go(1'b0, lat, nb);
    chk("xor_slen", 32'(S_len), 32'd10);
    chk("xor_s2", 32'(S[2]), 32'hF0);
    chk("xor_s3", 32'(S[3]), 32'h0F);
    chk("xor_s9", 32'(S[9]), 32'h0F);
    chk("xor_s10", 32'(S[10]), 32'd0);

    for (int i = 0; i < N; i++) begin A[i] = 8'd100; B[i] = 8'd100; end
    setup(3'd2, 1'b0, 0, 2, 2);
    go(1'b0, lat, nb);
`ifdef VECTOR_ALU_SATURATE_EN
    chk("mul_ovf", 32'(S[1]), 32'd127);
`else
    chk("mul_ovf", 32'(S[1]), 32'h10);
`endif

    for (int i = 0; i < N; i++) begin A[i] = 8'hFF; B[i] = 8'h01; end
    setup(3'd3, 1'b0, 0, 1, 1);
    go(1'b0, lat, nb);
    chk("cmp_lt", 32'(S[0]), 32'hFF);

    setup(3'd0, 1'b0, 0, 0, 0);
    go(1'b0, lat, nb);
    chk("zero_lat", 32'(lat), 32'd1);
    chk("zero_busy", 32'(nb), 32'd0);
    chk("zero_slen", 32'(S_len), 32'd0);

    for (int i = 0; i < N; i++) begin A[i] = 8'h30; B[i] = 8'h03; end
    setup(3'd5, 1'b0, 0, 200, 70);
    go(1'b1, lat, nb);
    chk("hold_lat", 32'(lat), 32'd9);
    chk("clamp_slen", 32'(S_len), 32'd64);
    chk("clamp_s63", 32'(S[63]), 32'h33);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_idle", 32'(busy), 32'd0);

    setup(3'd0, 1'b0, 0, 64, 64);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_slen", 32'(S_len), 32'd0);
    chk("abort_s", 32'(S[0] | S[8] | S[16]), 32'd0);

    for (int n = 0; n < 150; n++) begin
      scramble();
      if ($urandom_range(0, 3) == 0) A_len = BITS'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) B_len = BITS'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < N; i++)
          A[i] = BITS'($urandom_range(0, 1) ? MAXV : MINV);
      end
      go(1'($urandom), lat, nb);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
